dot_product_engine: RTL and testbench
=====================================

// Module: dot_product_engine
// PURPOSE
//  Compute stage downstream of axi_slave: on start_compute, streams vector_len element
//  pairs from local vector RAM (A, B banks), signed multiply-accumulates them, writes the
//  scalar result to the output address and pulses processing_done back to axi_slave.
//  Sits between the slave control block and the shared vector/result RAM.
// PARAMETERS
//  DATA_W  32  element and result width (signed two's complement)
//  ADDR_W  32  RAM word-address width; one element per address
//  LEN_W   32  vector length width
//  ACC_W   64  internal accumulator width (>= 2*DATA_W)
// PORTS
//  clk              in   1       system clock, rising edge
//  rst              in   1       asynchronous reset, active-low
//  start_compute    in   1       single-cycle start request from axi_slave
//  waddr_a          in   ADDR_W  base address of vector A
//  waddr_b          in   ADDR_W  base address of vector B
//  waddr_output     in   ADDR_W  result write address
//  vector_len       in   LEN_W   number of elements N
//  rd_en            out  1       RAM read strobe, both banks
//  rd_addr_a        out  ADDR_W  bank A read address
//  rd_addr_b        out  ADDR_W  bank B read address
//  rd_data_a        in   DATA_W  bank A data, valid 1 cycle after rd_en
//  rd_data_b        in   DATA_W  bank B data, valid 1 cycle after rd_en
//  wr_en            out  1       result write strobe
//  wr_addr          out  ADDR_W  result address
//  wr_data          out  DATA_W  result data
//  busy             out  1       high from accepted start until processing_done
//  processing_done  out  1       single-cycle completion pulse
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, accumulator and index cleared. Reset mid-run aborts
//    immediately; no wr_en and no processing_done are produced for the aborted job.
//  - FSM: IDLE -> RUN -> DRAIN -> WRITE -> DONE -> IDLE.
//    IDLE: when start_compute=1, latch waddr_a/b, waddr_output, vector_len; clear acc.
//      If vector_len=0 go to WRITE, else RUN. start_compute outside IDLE is ignored.
//    RUN: index i = 0..N-1; rd_en=1, rd_addr_x = base_x + i (ADDR_W wrap-around allowed).
//      Go to DRAIN after issuing i=N-1.
//    DRAIN: 2 cycles, no reads; the pipeline empties.
//    WRITE: wr_en=1 for 1 cycle, wr_addr=latched output address, wr_data=result.
//    DONE: processing_done=1 for 1 cycle, busy=0 from the next cycle.
//  - Pipeline: read issued at cycle k; data at k+1; registered signed product
//    (2*DATA_W) at end of k+1; sign-extended add into ACC_W accumulator at end of k+2.
//  - Timing (start sampled at cycle 0): reads at cycles 1..N, WRITE at N+3, processing_done
//    at N+4. N=0: WRITE at cycle 1, processing_done at cycle 2, result 0.
//  - Accumulator wraps modulo 2^ACC_W. busy=1 from cycle 1 through the processing_done cycle.
// CONFIGURATION
//  DOTP_SAT_EN defined: wr_data = accumulator saturated to the signed DATA_W range
//    (max 2^(DATA_W-1)-1, min -2^(DATA_W-1)).
//  DOTP_SAT_EN undefined: wr_data = accumulator[DATA_W-1:0], truncated and wrapping.
// STRUCTURE
//  - dotp_pkg: FSM state enum, DRAIN_CYCLES=2, default width constants.
//  - One sub-module, dotp_mac: product register, accumulator, and clear/enable controls,
//    plus the saturation/truncation output stage.
//  - The FSM, index counter and address generation stay in dot_product_engine.
// TESTING
//  - A=[1,2,3,4] @0x1000, B=[5,6,7,8] @0x2000, N=4, out 0x3000 -> wr_en at cycle 7,
//    wr_data=70 at 0x3000; processing_done at cycle 8.
//  - N=0 -> no rd_en; wr_data=0 at cycle 1; processing_done at cycle 2.
//  - A=[-3,2], B=[4,-5] -> wr_data=32'hFFFFFFEA (-22).
//  - A=B=[32'h7FFFFFFF, 32'h7FFFFFFF] -> wr_data=32'h7FFFFFFF with DOTP_SAT_EN;
//    wr_data=32'h00000002 without it.
//  - start_compute re-asserted during RUN -> ignored; exactly one wr_en and one
//    processing_done are produced.
//  - rst driven to 0 during RUN (N=4, cycle 2) -> outputs 0 at once; no wr_en or
//    processing_done; a new start after release completes normally.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared definitions for the dot-product compute stage: default widths,
// drain length and the controller state encoding.
// No ports (package).
package dotp_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned LEN_W_DEF    = 32;
    localparam int unsigned ACC_W_DEF    = 64;

    // Cycles spent after the last read so the read/multiply/accumulate pipe empties
    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dot_product_engine_if.sv
// Control and RAM-side signal bundle of the dot-product engine.
//   slave  : engine view (control in, RAM read data in; RAM strobes, result, status out)
//   master : environment view (control block + vector/result RAM)
interface dot_product_engine_if
    import dotp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);

    logic              start_compute;
    logic [ADDR_W-1:0] waddr_a;
    logic [ADDR_W-1:0] waddr_b;
    logic [ADDR_W-1:0] waddr_output;
    logic [LEN_W-1:0]  vector_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              processing_done;

    modport slave (
        input  start_compute, waddr_a, waddr_b, waddr_output, vector_len,
        input  rd_data_a, rd_data_b,
        output rd_en, rd_addr_a, rd_addr_b,
        output wr_en, wr_addr, wr_data,
        output busy, processing_done
    );

    modport master (
        output start_compute, waddr_a, waddr_b, waddr_output, vector_len,
        output rd_data_a, rd_data_b,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr, wr_data,
        input  busy, processing_done
    );

endinterface

// File: rtl/dotp_mac.sv
// Signed multiply-accumulate datapath with result output stage.
//   clk, rst            : clock, asynchronous active-low reset
//   clear               : zero the accumulator (start of a job)
//   rd_valid            : a RAM read is being issued this cycle
//   rd_data_a/b         : RAM data, valid one cycle after rd_valid
//   load                : capture the final accumulator into result
//   result              : registered result (DATA_W)
// Build option DOTP_SAT_EN: saturate the result to the signed DATA_W range
// instead of truncating.
module dotp_mac
    import dotp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data_a,
    input  logic [DATA_W-1:0] rd_data_b,
    input  logic              load,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic                     data_vld;
    logic                     prod_vld;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0]        result_next;

    // Next accumulator value; also feeds the result stage so the final product is included
    always_comb begin
        acc_next = acc;
        if (clear) begin
            acc_next = '0;
        end else if (prod_vld) begin
            acc_next = acc + ACC_W'(prod);
        end
    end

`ifdef DOTP_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Clamp to the signed DATA_W range
    always_comb begin
        result_next = acc_next[DATA_W-1:0];
        if (acc_next > SAT_MAX) begin
            result_next = SAT_MAX[DATA_W-1:0];
        end else if (acc_next < SAT_MIN) begin
            result_next = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    // Plain truncation, wraps modulo 2^DATA_W
    always_comb begin
        result_next = acc_next[DATA_W-1:0];
    end
`endif

    // Pipeline: data at k+1, product registered end of k+1, accumulated end of k+2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_vld <= 1'b0;
            prod_vld <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            result   <= '0;
        end else begin
            data_vld <= rd_valid;
            prod_vld <= data_vld;
            if (data_vld) begin
                prod <= PROD_W'($signed(rd_data_a)) * PROD_W'($signed(rd_data_b));
            end
            acc <= acc_next;
            if (load) begin
                result <= result_next;
            end
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product compute stage: on start_compute streams vector_len element pairs
// from the A/B banks, multiply-accumulates them, writes the scalar result and
// pulses processing_done.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : dot_product_engine_if.slave (control, RAM read/write, status)
// Build option DOTP_SAT_EN (in dotp_mac): saturating result instead of truncation.
module dot_product_engine
    import dotp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    dot_product_engine_if.slave    bus
);

    state_t              state;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    issued;      // reads issued so far, including the current one
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_a_q;
    logic [ADDR_W-1:0]   rd_addr_b_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                start_c;
    logic                last_drain_c;
    logic                clear_c;
    logic                load_c;

    // Datapath controls: clear on job accept, load result as the last product lands
    always_comb begin
        start_c      = 1'b0;
        last_drain_c = 1'b0;
        clear_c      = 1'b0;
        load_c       = 1'b0;
        start_c      = (state == ST_IDLE) && bus.start_compute;
        last_drain_c = (state == ST_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
        clear_c      = start_c;
        load_c       = last_drain_c || (start_c && (bus.vector_len == '0));
    end

    // Controller FSM, read index/address generation and registered strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            issued      <= '0;
            drain_cnt   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_compute) begin
                        len_q     <= bus.vector_len;
                        wr_addr_q <= bus.waddr_output;
                        busy_q    <= 1'b1;
                        if (bus.vector_len == '0) begin
                            wr_en_q <= 1'b1;
                            state   <= ST_WRITE;
                        end else begin
                            rd_en_q     <= 1'b1;
                            rd_addr_a_q <= bus.waddr_a;
                            rd_addr_b_q <= bus.waddr_b;
                            issued      <= LEN_W'(1);
                            state       <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issued == len_q) begin
                        rd_en_q   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        rd_addr_a_q <= rd_addr_a_q + ADDR_W'(1);
                        rd_addr_b_q <= rd_addr_b_q + ADDR_W'(1);
                        issued      <= issued + LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (last_drain_c) begin
                        wr_en_q <= 1'b1;
                        state   <= ST_WRITE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_WRITE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dotp_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_c),
        .rd_valid  (rd_en_q),
        .rd_data_a (bus.rd_data_a),
        .rd_data_b (bus.rd_data_b),
        .load      (load_c),
        .result    (bus.wr_data)
    );

    assign bus.rd_en           = rd_en_q;
    assign bus.rd_addr_a       = rd_addr_a_q;
    assign bus.rd_addr_b       = rd_addr_b_q;
    assign bus.wr_en           = wr_en_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.busy            = busy_q;
    assign bus.processing_done = done_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Testbench for dot_product_engine: RAM model, directed jobs, scoreboard monitor.
module tb_dot_product_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dot_product_engine_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(32)) bus ();

    dot_product_engine #(
        .DATA_W (32),
        .ADDR_W (32),
        .LEN_W  (32),
        .ACC_W  (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          reads;
        int          wr_cyc;
    } exp_t;

    exp_t        wq[$];
    int          dq[$];
    exp_t        mon_e;
    int          mon_d;
    int          cyc    = 0;
    int          reads  = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Synchronous RAM model: data one cycle after rd_en
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= ram_rd(bus.rd_addr_a);
            bus.rd_data_b <= ram_rd(bus.rd_addr_b);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or signals done
    always @(negedge clk) begin
        if (!rst) begin
            reads = 0;
        end else begin
            if (bus.rd_en) reads++;
            if (bus.wr_en) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got wr_en=1 at cycle %0d expected none", cyc);
                end else begin
                    mon_e = wq.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
                    check("wr_cycle", 64'(cyc), 64'(mon_e.wr_cyc));
                    check("read_count", 64'(reads), 64'(mon_e.reads));
                    dq.push_back(mon_e.wr_cyc + 1);
                end
                reads = 0;
            end
            if (bus.processing_done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got processing_done=1 at cycle %0d expected none", cyc);
                end else begin
                    mon_d = dq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_d));
                end
            end
        end
    end

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
    endtask

    task automatic drive_start(input logic [31:0] a_base, input logic [31:0] b_base,
                               input logic [31:0] out_addr, input int n);
        bus.start_compute = 1'b1;
        bus.waddr_a       = a_base;
        bus.waddr_b       = b_base;
        bus.waddr_output  = out_addr;
        bus.vector_len    = 32'(n);
    endtask

    task automatic run_job(input logic [31:0] a_base, input logic [31:0] b_base,
                           input logic [31:0] out_addr, input int n,
                           input logic [31:0] exp_data, input bit restart);
        exp_t e;
        int   s;
        bit   seen;
        @(negedge clk);
        s        = cyc;
        e.addr   = out_addr;
        e.data   = exp_data;
        e.reads  = n;
        e.wr_cyc = (n == 0) ? s + 1 : s + n + 3;
        wq.push_back(e);
        drive_start(a_base, b_base, out_addr, n);
        @(negedge clk);
        bus.start_compute = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("rd_en_first", 64'(bus.rd_en), 64'(n > 0));
        if (restart) begin
            @(negedge clk);
            drive_start(32'h0, 32'h0, 32'hDEAD0000, 1);
            @(negedge clk);
            bus.start_compute = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < n + 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.processing_done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("busy_after_done", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(wq.size() + dq.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.processing_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start_compute = 1'b0;
        bus.waddr_a       = '0;
        bus.waddr_b       = '0;
        bus.waddr_output  = '0;
        bus.vector_len    = '0;

        // Vectors: A=[1,2,3,4] B=[5,6,7,8]
        put(32'h1000, 32'd1); put(32'h1001, 32'd2); put(32'h1002, 32'd3); put(32'h1003, 32'd4);
        put(32'h2000, 32'd5); put(32'h2001, 32'd6); put(32'h2002, 32'd7); put(32'h2003, 32'd8);
        // A=[-3,2] straddling the address wrap, B=[4,-5]
        put(32'hFFFFFFFF, 32'hFFFFFFFD); put(32'h0000_0000, 32'd2);
        put(32'h4000, 32'd4); put(32'h4001, 32'hFFFFFFFB);
        // A=B=[max,max]
        put(32'h5000, 32'h7FFFFFFF); put(32'h5001, 32'h7FFFFFFF);

        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_wr_data", 64'(bus.wr_data), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(32'h1000, 32'h2000, 32'h3000, 4, 32'd70, 1'b0);
        run_job(32'h0, 32'h0, 32'h3004, 0, 32'd0, 1'b0);
        run_job(32'hFFFFFFFF, 32'h4000, 32'h3008, 2, 32'hFFFFFFEA, 1'b0);
`ifdef DOTP_SAT_EN
        run_job(32'h5000, 32'h5000, 32'h300C, 2, 32'h7FFFFFFF, 1'b0);
`else
        run_job(32'h5000, 32'h5000, 32'h300C, 2, 32'h00000002, 1'b0);
`endif
        run_job(32'h1000, 32'h2000, 32'h3010, 4, 32'd70, 1'b1);

        // Abort a job mid-RUN with reset; nothing may be written for it
        @(negedge clk);
        drive_start(32'h1000, 32'h2000, 32'h3014, 4);
        @(negedge clk);
        bus.start_compute = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_quiet("abort");
        repeat (3) @(negedge clk);
        check_quiet("abort_hold");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_write", 64'(wq.size() + dq.size()), 64'd0);

        run_job(32'h1000, 32'h2000, 32'h3018, 4, 32'd70, 1'b0);

        check("final_queue", 64'(wq.size() + dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
